// File: rtl/spram_fifo_ctrl.sv
// FIFO controller arbitrating one external single-port RAM between pushes and pops.
// Optional almost_full output is enabled by defining SPRAM_FIFO_CTRL_ALMOST_FULL_EN.
module spram_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 2
`ifdef SPRAM_FIFO_CTRL_ALMOST_FULL_EN
    ,
    parameter int unsigned AFULL_LEVEL = 3
`endif
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_wen,
`ifdef SPRAM_FIFO_CTRL_ALMOST_FULL_EN
    output logic                  almost_full,
`endif
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam logic [ADDR_WIDTH:0] CntFull = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] CntZero = '0;

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_ram_cnt;
    logic                  r_m_valid;
    logic                  r_last_rd;

    logic [ADDR_WIDTH-1:0] w_wr_ptr_nxt;
    logic [ADDR_WIDTH-1:0] w_rd_ptr_nxt;
    logic [ADDR_WIDTH:0]   w_ram_cnt_nxt;
    logic                  w_m_valid_nxt;
    logic                  w_last_rd_nxt;
    logic                  w_rd_req;
    logic                  w_wr_req;
    logic                  w_rd_grant;
    logic                  w_wr_grant;
    logic                  w_not_full;

    assign w_not_full = (r_ram_cnt != CntFull);
    assign w_rd_req   = (r_ram_cnt != CntZero) && (!r_m_valid || m_ready);
    assign w_wr_req   = s_valid && w_not_full;

    // An empty head always wins; otherwise alternate so neither side starves.
    assign w_rd_grant = w_rd_req && (!w_wr_req || !r_m_valid || !r_last_rd);
    assign w_wr_grant = w_wr_req && !w_rd_grant;

    always_comb begin
        w_wr_ptr_nxt  = r_wr_ptr;
        w_rd_ptr_nxt  = r_rd_ptr;
        w_ram_cnt_nxt = r_ram_cnt;
        w_m_valid_nxt = r_m_valid;
        w_last_rd_nxt = r_last_rd;
        if (w_wr_grant) begin
            w_wr_ptr_nxt  = r_wr_ptr + ADDR_WIDTH'(1);
            w_ram_cnt_nxt = r_ram_cnt + (ADDR_WIDTH + 1)'(1);
            w_last_rd_nxt = 1'b0;
        end else if (w_rd_grant) begin
            w_rd_ptr_nxt  = r_rd_ptr + ADDR_WIDTH'(1);
            w_ram_cnt_nxt = r_ram_cnt - (ADDR_WIDTH + 1)'(1);
            w_last_rd_nxt = 1'b1;
        end
        if (w_rd_grant) begin
            w_m_valid_nxt = 1'b1;
        end else if (r_m_valid && m_ready) begin
            w_m_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ram_cnt <= '0;
            r_m_valid <= 1'b0;
            r_last_rd <= 1'b0;
        end else begin
            r_wr_ptr  <= w_wr_ptr_nxt;
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_ram_cnt <= w_ram_cnt_nxt;
            r_m_valid <= w_m_valid_nxt;
            r_last_rd <= w_last_rd_nxt;
        end
    end

    assign ram_addr = w_rd_grant ? r_rd_ptr : r_wr_ptr;
    assign ram_wen  = w_wr_grant;
    assign ram_din  = s_data;
    assign s_ready  = w_not_full && !w_rd_grant;
    assign m_valid  = r_m_valid;
    assign m_data   = ram_dout;
    assign count    = r_ram_cnt + {{ADDR_WIDTH{1'b0}}, r_m_valid};

`ifdef SPRAM_FIFO_CTRL_ALMOST_FULL_EN
    assign almost_full = (32'(count) >= AFULL_LEVEL);
`endif

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Self-checking bench for spram_fifo_ctrl with a behavioural single-port RAM and
// a scoreboard queue holding every accepted word until it is popped.
module tb_spram_fifo_ctrl;

    localparam int DW = 32;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [AW:0]   count;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_wen;
    logic [DW-1:0] ram_dout;
`ifdef SPRAM_FIFO_CTRL_ALMOST_FULL_EN
    logic          almost_full;
`endif

    logic [DW-1:0] mem [4] = '{default: '0};
    logic [DW-1:0] q [$];
    logic [AW-1:0] tb_wp = '0;
    int            n_vec = 0;
    int            n_err = 0;

    spram_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .count       (count),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_wen     (ram_wen),
`ifdef SPRAM_FIFO_CTRL_ALMOST_FULL_EN
        .almost_full (almost_full),
`endif
        .ram_dout    (ram_dout)
    );

    always #5 clk = ~clk;

    // RAM read strobe: no read while the head is held, so dout stays put; a read
    // on any other idle cycle is harmless because m_valid is dropping anyway.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ram_dout <= '0;
        end else if (ram_wen) begin
            mem[ram_addr] <= ram_din;
        end else if (m_ready || !m_valid) begin
            ram_dout <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge: scoreboard checks, then advance to just after posedge.
    task automatic step(output bit acc);
        logic [DW-1:0] head;
        acc = s_valid && s_ready;
        chk("count", 64'(count), 64'(q.size()));
        chk("ram_wen", 64'(ram_wen), 64'(acc));
        if (ram_wen) begin
            chk("ram_addr_wr", 64'(ram_addr), 64'(tb_wp));
            chk("ram_din", 64'(ram_din), 64'(s_data));
        end
`ifdef SPRAM_FIFO_CTRL_ALMOST_FULL_EN
        chk("almost_full", 64'(almost_full), 64'(q.size() >= 3));
`endif
        if (m_valid && m_ready) begin
            if (q.size() == 0) begin
                chk("pop_when_empty", 64'(m_valid), 64'(0));
            end else begin
                head = q.pop_front();
                chk("m_data", 64'(m_data), 64'(head));
            end
        end
        if (acc) begin
            q.push_back(s_data);
            tb_wp++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        int v;
        int sent;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_s_ready", 64'(s_ready), 64'(1));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_m_data", 64'(m_data), 64'(0));
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Single push
        s_valid = 1'b1;
        s_data  = 32'hA5A5_0001;
        m_ready = 1'b1;
        @(negedge clk);
        chk("sp_c0_wen", 64'(ram_wen), 64'(1));
        chk("sp_c0_s_ready", 64'(s_ready), 64'(1));
        step(acc);
        s_valid = 1'b0;
        @(negedge clk);
        chk("sp_c1_rd_grant", 64'(s_ready), 64'(0));
        chk("sp_c1_rd_addr", 64'(ram_addr), 64'(0));
        chk("sp_c1_m_valid", 64'(m_valid), 64'(0));
        step(acc);
        @(negedge clk);
        chk("sp_c2_m_valid", 64'(m_valid), 64'(1));
        chk("sp_c2_m_data", 64'(m_data), 64'h0000_0000_A5A5_0001);
        step(acc);
        @(negedge clk);
        chk("sp_c3_count", 64'(count), 64'(0));
        chk("sp_c3_m_valid", 64'(m_valid), 64'(0));
        step(acc);

        // Fill
        m_ready = 1'b0;
        v = 1;
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(v);
            @(negedge clk);
            step(acc);
            if (acc) v++;
        end
        s_valid = 1'b0;
        @(negedge clk);
        chk("fill_accepted", 64'(v - 1), 64'(5));
        chk("fill_count", 64'(count), 64'(5));
        chk("fill_s_ready", 64'(s_ready), 64'(0));
        chk("fill_m_valid", 64'(m_valid), 64'(1));
        chk("fill_m_data", 64'(m_data), 64'(1));
        step(acc);

        // Drain
        m_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("drain_m_valid", 64'(m_valid), 64'(1));
            chk("drain_m_data", 64'(m_data), 64'(i));
            step(acc);
        end
        @(negedge clk);
        chk("drain_end_m_valid", 64'(m_valid), 64'(0));
        chk("drain_end_count", 64'(count), 64'(0));
        step(acc);

        // Contention
        sent = 0;
        for (int cyc = 0; cyc < 4000 && sent < 200; cyc++) begin
            s_valid = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            s_data  = $urandom;
            @(negedge clk);
            step(acc);
            if (acc) sent++;
        end
        chk("cont_sent", 64'(sent), 64'(200));
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(negedge clk);
            step(acc);
        end
        @(negedge clk);
        chk("cont_end_count", 64'(count), 64'(0));
        chk("cont_end_m_valid", 64'(m_valid), 64'(0));
        step(acc);

        // Reset mid-stream
        m_ready = 1'b0;
        v = 'h10;
        for (int i = 0; i < 10 && q.size() < 3; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(v);
            @(negedge clk);
            step(acc);
            if (acc) v++;
        end
        s_valid = 1'b0;
        @(negedge clk);
        chk("mid_count_pre", 64'(count), 64'(3));
        step(acc);
        resetn = 1'b0;
        #1;
        chk("mid_m_valid", 64'(m_valid), 64'(0));
        chk("mid_count", 64'(count), 64'(0));
        chk("mid_s_ready", 64'(s_ready), 64'(1));
        q.delete();
        tb_wp = '0;
        #2;
        resetn = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'h77;
        m_ready = 1'b1;
        @(negedge clk);
        step(acc);
        chk("mid_push77", 64'(acc), 64'(1));
        s_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            step(acc);
        end
        chk("mid_popped77", 64'(q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
